sik_mem_arbiter: RTL and testbench
==================================

Name: sik_mem_arbiter

Overview:
- Shares the single-port 64K x 16 main memory between two requesters of the stack processor: the instruction-fetch unit (read-only) and the data unit (Load/Store).
- Sequences every memory access with a 4-state FSM and arbitrates round-robin when both requesters are active.
- Sits between the processor core and the mainmem RAM model.
- The core never drives the RAM directly.

Parameters:
- AW, 16, address width; the word address range is 0..2^AW-1.
- DW, 16, data word width.

Ports:
- clk, input, 1, system clock; all state updates on the posedge.
- reset, input, 1, asynchronous active-low reset: reset=0 clears the block immediately; normal operation when reset=1.
- halt, input, 1, core halted: no new grants; any in-flight transaction completes.
- f_req, input, 1, fetch request; held high until f_ack.
- f_addr, input, AW, fetch word address; stable while f_req is high.
- f_ack, output, 1, one-cycle pulse: fetch done, f_rdata valid.
- f_rdata, output, DW, fetched word; holds its value until the next fetch completes.
- d_req, input, 1, data request; held high until d_ack.
- d_we, input, 1, 1 = Store, 0 = Load; stable while d_req is high.
- d_addr, input, AW, data word address.
- d_wdata, input, DW, Store data.
- d_ack, output, 1, one-cycle pulse: data transaction done; d_rdata valid for a Load.
- d_rdata, output, DW, Load result; holds its value until the next Load completes.
- mem_en, output, 1, RAM access strobe (registered).
- mem_we, output, 1, RAM write enable (registered; only ever high together with mem_en).
- mem_addr, output, AW, RAM address (registered).
- mem_wdata, output, DW, RAM write data (registered).
- mem_rdata, input, DW, RAM read data; valid in the cycle after the edge that sampled mem_en=1.
- busy, output, 1, high in every state except IDLE.
- gnt_d, output, 1, owner of the current transaction: 0 = fetch, 1 = data. Valid while busy=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0 (f_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, f_rdata, d_rdata, busy, gnt_d).
  - last_d=1, so fetch wins the first tie.
  - Reset mid-transaction aborts it with no ack. A write whose mem_en/mem_we were already registered is dropped, because mem_we is forced 0 asynchronously.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, at the clock edge:
  - If halt=1, or neither f_req nor d_req is high: stay in IDLE.
  - If only one request is high: grant it.
  - If both are high: grant fetch when last_d=1, otherwise grant data. Set last_d=gnt_d.
  - On a grant: register mem_en=1, mem_addr from the winner, mem_we=(winner is data && d_we), mem_wdata=d_wdata. Set gnt_d, busy=1, go to ISSUE.
- ISSUE:
  - The RAM samples the request at this edge.
  - At the edge: mem_en=0, mem_we=0, go to WAIT. mem_addr and mem_wdata hold their values.
- WAIT:
  - mem_rdata is valid.
  - At the edge: if gnt_d=0, f_rdata<=mem_rdata. If gnt_d=1 and it is a Load, d_rdata<=mem_rdata. A Store leaves d_rdata unchanged.
  - Assert the winner's ack (f_ack or d_ack) and go to RESP.
- RESP:
  - The ack is high for exactly this one cycle.
  - At the edge: ack=0, busy=0, go to IDLE. The request is not re-sampled at this edge.
- Latency: request sampled high at edge E0 -> ack high during the cycle after E2 -> IDLE after E3. Throughput is one access per 4 cycles.
- Requester protocol:
  - Drop req during the ack cycle; it is next sampled in IDLE after E3.
  - If req is still high in IDLE, it is treated as a new request (re-serviced).
  - Address, data and d_we changes while req is high and not yet granted are allowed; the values at the grant edge are used.
- halt:
  - Checked only in IDLE.
  - halt rising during ISSUE/WAIT/RESP does not abort; the transaction completes and its ack is still issued.
- Never grants both requesters; f_ack and d_ack are never high together.
- Addresses wrap naturally at AW bits; there is no range checking.
- A request arriving in IDLE is never granted in the same cycle; no combinational path exists from req to mem_*.

Test Plan:
1. Reset, then f_req=1, f_addr=16'h0010, RAM[0x10]=16'hA5A5 -> mem_en=1/mem_addr=0x0010 one cycle after E0; f_ack pulses exactly once, 3 cycles after E0; f_rdata=16'hA5A5; d_ack stays 0.
2. Data Store d_we=1, d_addr=16'h0100, d_wdata=16'h1234, then Load from the same address -> exactly one mem_we=1 cycle; Load d_rdata=16'h1234; d_rdata is unchanged by the Store's completion.
3. f_req and d_req both held continuously high -> grant order after reset: fetch, data, fetch, data. Acks are spaced 4 cycles apart; never simultaneous.
4. halt=1 with f_req=1 in IDLE -> busy stays 0 and mem_en stays 0 for 10 cycles; drop halt -> transaction starts on the next edge.
5. halt raised in the WAIT cycle of a Load -> d_ack is still issued with the correct d_rdata; no further grants.
6. reset pulled low asynchronously (between edges) during ISSUE of a Store -> mem_we=0 and busy=0 immediately; no ack; the RAM contents at that address are unchanged; the first post-reset tie goes to fetch.

Source files
------------

// File: rtl/sik_mem_arbiter.sv
// Round-robin arbiter sharing the single-port main memory between instruction
// fetch (read-only) and the data unit (Load/Store), one access per four cycles.
//
// state | meaning
// IDLE  | waiting for a request; grant decision made here only
// ISSUE | mem_en/mem_we registered, RAM samples the access at this edge
// WAIT  | mem_rdata valid; captured into winner's rdata, ack raised
// RESP  | ack high for this one cycle, then back to IDLE
module sik_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state;
  logic   last_d;
  logic   xfer_we;
  logic   pick_d;

  // Data wins when it is alone, or on a tie when fetch was served last.
  assign pick_d = d_req && (!f_req || !last_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      xfer_we   <= 1'b0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      gnt_d     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt && (f_req || d_req)) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            gnt_d     <= pick_d;
            last_d    <= pick_d;
            mem_en    <= 1'b1;
            mem_addr  <= pick_d ? d_addr : f_addr;
            mem_we    <= pick_d && d_we;
            xfer_we   <= pick_d && d_we;
            mem_wdata <= d_wdata;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (!gnt_d) begin
            f_rdata <= mem_rdata;
            f_ack   <= 1'b1;
          end else begin
            if (!xfer_we) d_rdata <= mem_rdata;
            d_ack <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sik_mem_arbiter.sv
// Directed bench for sik_mem_arbiter with a synchronous 64K x 16 RAM model.
module tb_sik_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        gnt_d;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] ram [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int both_cnt = 0;
  int bad_we   = 0;

  sik_mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .halt      (halt),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .gnt_d     (gnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preload port for bench setup, otherwise driven by the arbiter.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt++;
    if (f_ack === 1'b1 && d_ack === 1'b1) both_cnt++;
    if (mem_we === 1'b1 && mem_en !== 1'b1) bad_we++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst acks", {f_ack, d_ack}, 0);
    chk("rst rdata", {f_rdata, d_rdata}, 0);
    chk("rst gnt_d", gnt_d, 0);

    pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 16'hA5A5;
    tick();
    pre_addr = 16'h0200; pre_data = 16'h5555;
    tick();
    pre_we = 1'b0;
    reset = 1'b1;
    tick();

    // Fetch from 0x0010
    f_req = 1'b1; f_addr = 16'h0010;
    tick();
    chk("t1 mem_en", mem_en, 1);
    chk("t1 mem_addr", mem_addr, 16'h0010);
    chk("t1 gnt_d", gnt_d, 0);
    chk("t1 busy", busy, 1);
    chk("t1 early ack", f_ack, 0);
    tick();
    chk("t1 issue done", {mem_en, f_ack}, 0);
    tick();
    chk("t1 f_ack", f_ack, 1);
    chk("t1 f_rdata", f_rdata, 16'hA5A5);
    chk("t1 d_ack", d_ack, 0);
    f_req = 1'b0;
    tick();
    chk("t1 ack drop", {f_ack, busy}, 0);
    tick();
    chk("t1 idle", {busy, mem_en}, 0);

    // Store 0x1234 to 0x0100, then Load it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    tick();
    chk("t2 st we", {mem_en, mem_we}, 2'b11);
    chk("t2 st addr", mem_addr, 16'h0100);
    chk("t2 st wdata", mem_wdata, 16'h1234);
    chk("t2 st gnt_d", gnt_d, 1);
    tick();
    chk("t2 st we off", mem_we, 0);
    tick();
    chk("t2 st ack", {f_ack, d_ack}, 2'b01);
    chk("t2 st rdata kept", d_rdata, 0);
    d_req = 1'b0;
    tick();
    chk("t2 ram", ram[16'h0100], 16'h1234);
    chk("t2 we cycles", we_cnt, 1);
    d_req = 1'b1; d_we = 1'b0;
    tick();
    chk("t2 ld we", {mem_en, mem_we}, 2'b10);
    tick();
    tick();
    chk("t2 ld ack", d_ack, 1);
    chk("t2 ld rdata", d_rdata, 16'h1234);
    d_req = 1'b0;
    tick();

    // Continuous tie: fetch, data, fetch, data
    f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0010; d_addr = 16'h0100; d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3 gnt", gnt_d, k % 2);
      tick();
      tick();
      chk("t3 acks", {f_ack, d_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 2 == 0) chk("t3 f_rdata", f_rdata, 16'hA5A5);
      else            chk("t3 d_rdata", d_rdata, 16'h1234);
      tick();
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();

    // halt blocks grants in IDLE
    halt = 1'b1; f_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4 halted", {busy, mem_en}, 0);
    end
    halt = 1'b0;
    tick();
    chk("t4 start", {busy, mem_en, gnt_d}, 3'b110);
    tick();
    tick();
    chk("t4 f_ack", f_ack, 1);
    f_req = 1'b0;
    tick();

    // halt raised in WAIT of a Load
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    tick();
    chk("t5 gnt_d", gnt_d, 1);
    tick();
    halt = 1'b1; f_req = 1'b1;
    tick();
    chk("t5 d_ack", d_ack, 1);
    chk("t5 d_rdata", d_rdata, 16'hA5A5);
    tick();
    chk("t5 done", {busy, d_ack}, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5 no grant", {busy, mem_en}, 0);
    end
    f_req = 1'b0; d_req = 1'b0;
    halt = 1'b0;
    tick();

    // Async reset during ISSUE of a Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    tick();
    chk("t6 we set", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6 async clear", {mem_we, mem_en, busy}, 0);
    d_req = 1'b0;
    tick();
    tick();
    chk("t6 no ack", {f_ack, d_ack}, 0);
    chk("t6 ram kept", ram[16'h0200], 16'h5555);
    reset = 1'b1;
    tick();
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 16'h0010; d_addr = 16'h0100;
    tick();
    chk("t6 tie fetch", {busy, gnt_d}, 2'b10);
    tick();
    tick();
    chk("t6 f_ack", {f_ack, d_ack}, 2'b10);
    f_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    chk("acks never together", both_cnt, 0);
    chk("we only with en", bad_we, 0);
    chk("total we cycles", we_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
